// File: rtl/reg_writeback.sv
// Register-file write initiator: queues (rd, value) results in a small FIFO and issues them
// one at a time over the write_enable / write_done handshake, with hazard lookup on queued entries.
module reg_writeback #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd,
  input  logic [63:0] in_value,
  output logic        write_enable,
  output logic [4:0]  write_register,
  output logic [63:0] write_value,
  input  logic        write_done,
  input  logic [4:0]  query_reg1,
  input  logic [4:0]  query_reg2,
  output logic        query_hit1,
  output logic        query_hit2,
  output logic        idle,
  output logic        timeout_err,
  output logic [31:0] writes_done_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  logic [4:0]    fifo_rd  [DEPTH];
  logic [63:0]   fifo_val [DEPTH];
  logic [AW-1:0] head, tail, off;
  logic [AW:0]   count;
  logic [WW-1:0] wait_cnt;
  state_t        state;
  logic          push, pop;

  assign in_ready = (count != FULL_CNT);
  // rd==0 is a handshake-only result: it consumes the slot offer but is never stored
  assign push     = in_valid && in_ready && (in_rd != 5'd0);
  assign pop      = (state == S_WAIT) && (write_done || wait_cnt == WAIT_LAST);
  assign idle     = (count == '0) && (state == S_IDLE);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[tail]  <= in_rd;
      fifo_val[tail] <= in_value;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // The head stays queued until retired, so in-flight writes still raise hazards
  always_comb begin
    query_hit1 = 1'b0;
    query_hit2 = 1'b0;
    off        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = AW'(i) - head;
      if ({1'b0, off} < count) begin
        if (query_reg1 != 5'd0 && fifo_rd[i] == query_reg1) query_hit1 = 1'b1;
        if (query_reg2 != 5'd0 && fifo_rd[i] == query_reg2) query_hit2 = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      write_enable    <= 1'b0;
      write_register  <= 5'd0;
      write_value     <= 64'd0;
      wait_cnt        <= '0;
      timeout_err     <= 1'b0;
      writes_done_cnt <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (count != '0) begin
            state          <= S_ISSUE;
            write_enable   <= 1'b1;
            write_register <= fifo_rd[head];
            write_value    <= fifo_val[head];
          end
        end
        S_ISSUE: begin
          state        <= S_WAIT;
          write_enable <= 1'b0;
          wait_cnt     <= '0;
        end
        S_WAIT: begin
          if (write_done) begin
            writes_done_cnt <= writes_done_cnt + 32'd1;
            state           <= S_IDLE;
          end else if (wait_cnt == WAIT_LAST) begin
            timeout_err <= 1'b1;
            state       <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          state        <= S_IDLE;
          write_enable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Bench for reg_writeback: cycle-stamped transaction model (each queued write's issue and retire
// cycles derived from acceptance/retire times) checked every cycle, plus directed literal checks.
module tb_reg_writeback;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_rd = 5'd0;
  logic [63:0] in_value = 64'd0;
  logic        write_enable;
  logic [4:0]  write_register;
  logic [63:0] write_value;
  logic        write_done;
  logic [4:0]  query_reg1 = 5'd0;
  logic [4:0]  query_reg2 = 5'd0;
  logic        query_hit1, query_hit2, idle, timeout_err;
  logic [31:0] writes_done_cnt;

  reg_writeback #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd),
    .in_value(in_value), .write_enable(write_enable), .write_register(write_register),
    .write_value(write_value), .write_done(write_done), .query_reg1(query_reg1),
    .query_reg2(query_reg2), .query_hit1(query_hit1), .query_hit2(query_hit2), .idle(idle),
    .timeout_err(timeout_err), .writes_done_cnt(writes_done_cnt)
  );

  always #5 clk = ~clk;

  // register-file responder: directed value or random pulses
  logic auto_done = 1'b0, man_done = 1'b0, rnd_done = 1'b0;
  int   done_pct = 100;
  always @(posedge clk) begin
    #1;
    rnd_done = ($urandom_range(0, 99) < done_pct);
  end
  assign write_done = auto_done ? rnd_done : man_done;

  int n_cmp = 0, n_bad = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // model: pending writes in acceptance order, each stamped with the cycle it was accepted
  typedef struct {logic [4:0] rd; logic [63:0] val; int acc;} ent_t;
  ent_t        q[$];
  ent_t        e;
  int          cyc = 0;
  int          prev_ret = -100;
  logic [31:0] m_cnt = 0;
  logic        m_err = 0;
  logic [4:0]  m_rd_last = 0;
  logic [63:0] m_val_last = 0;
  bit          chk_en = 0;
  bit          m_rdy;

  // a write pulses two cycles after both its acceptance and the previous retirement
  function automatic int issue_at();
    return ((q[0].acc > prev_ret) ? q[0].acc : prev_ret) + 2;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      prev_ret   = -100;
      m_cnt      = 0;
      m_err      = 0;
      m_rd_last  = 0;
      m_val_last = 0;
      chk_en     = 1;
    end else begin
      m_rdy = (q.size() < DEPTH);
      if (q.size() > 0 && cyc > issue_at()) begin
        if (write_done) begin
          void'(q.pop_front());
          m_cnt    = m_cnt + 1;
          prev_ret = cyc;
        end else if (cyc == issue_at() + TIMEOUT) begin
          void'(q.pop_front());
          m_err    = 1;
          prev_ret = cyc;
        end
      end
      if (in_valid && m_rdy && in_rd != 5'd0) begin
        e.rd = in_rd; e.val = in_value; e.acc = cyc;
        q.push_back(e);
      end
    end
    cyc++;
  end

  logic exp_we, h1, h2;
  always @(negedge clk) begin
    if (chk_en) begin
      exp_we = 0;
      if (q.size() > 0) begin
        if (cyc == issue_at()) exp_we = 1;
        if (cyc >= issue_at()) begin
          m_rd_last  = q[0].rd;
          m_val_last = q[0].val;
        end
      end
      h1 = 0; h2 = 0;
      foreach (q[i]) begin
        if (query_reg1 != 0 && q[i].rd == query_reg1) h1 = 1;
        if (query_reg2 != 0 && q[i].rd == query_reg2) h2 = 1;
      end
      check("in_ready", in_ready, q.size() < DEPTH);
      check("idle", idle, q.size() == 0);
      check("write_enable", write_enable, exp_we);
      check("write_register", write_register, m_rd_last);
      check("write_value", write_value, m_val_last);
      check("query_hit1", query_hit1, h1);
      check("query_hit2", query_hit2, h2);
      check("timeout_err", timeout_err, m_err);
      check("writes_done_cnt", writes_done_cnt, m_cnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while (!idle && k < 200) begin
      tick();
      k++;
    end
    check(nm, idle, 1'b1);
  endtask

  initial begin
    int k;
    bit acc;
    repeat (2) tick();
    reset = 1'b0;

    // single write: pulse at N+2, done at N+4
    in_valid = 1; in_rd = 5'd5; in_value = 64'hDEAD;
    tick();
    in_valid = 0;
    check("t1_we_n1", write_enable, 1'b0);
    tick();
    check("t1_we_n2", write_enable, 1'b1);
    check("t1_reg", write_register, 64'd5);
    check("t1_val", write_value, 64'hDEAD);
    tick();
    check("t1_we_n3", write_enable, 1'b0);
    tick();
    man_done = 1;
    tick();
    man_done = 0;
    check("t1_cnt", writes_done_cnt, 64'd1);
    check("t1_idle", idle, 1'b1);

    // five back-to-back into a four-entry FIFO
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        check("t2_full", in_ready, 1'b0);
        auto_done = 1;
      end
      in_valid = 1; in_rd = 5'(10 + i); in_value = 64'(100 + i);
      k = 0;
      do begin
        acc = in_ready;
        tick();
        k++;
      end while (!acc && k < 50);
      check("t2_accept", acc, 1'b1);
    end
    in_valid = 0;
    wait_idle("t2_idle");
    auto_done = 0;
    check("t2_cnt", writes_done_cnt, 64'd6);

    // rd 0 is accepted but never written
    in_valid = 1; in_rd = 5'd0; in_value = 64'd7;
    check("t3_ready", in_ready, 1'b1);
    tick();
    in_valid = 0;
    repeat (5) tick();
    check("t3_cnt", writes_done_cnt, 64'd6);
    check("t3_idle", idle, 1'b1);

    // hazard query on a pending write
    in_valid = 1; in_rd = 5'd9; in_value = 64'h99;
    tick();
    in_valid = 0; query_reg1 = 5'd9; query_reg2 = 5'd0;
    #1;
    check("t4_hit1", query_hit1, 1'b1);
    check("t4_hit2", query_hit2, 1'b0);
    man_done = 1;
    wait_idle("t4_idle");
    man_done = 0;
    #1;
    check("t4_hit1_after", query_hit1, 1'b0);
    check("t4_cnt", writes_done_cnt, 64'd7);

    // timeout: drop rd 3, then rd 4 issues
    in_valid = 1; in_rd = 5'd3; in_value = 64'h33;
    tick();
    in_rd = 5'd4; in_value = 64'h44;
    tick();
    in_valid = 0;
    k = 2;
    while (!timeout_err && k < 40) begin
      tick();
      k++;
    end
    check("t5_err", timeout_err, 1'b1);
    check("t5_err_cycle", k, 19);
    check("t5_cnt", writes_done_cnt, 64'd7);
    tick();
    check("t5_next_we", write_enable, 1'b1);
    check("t5_next_reg", write_register, 64'd4);
    man_done = 1;
    wait_idle("t5_idle");
    man_done = 0;
    check("t5_cnt2", writes_done_cnt, 64'd8);

    // reset during WAIT with three entries queued
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_rd = 5'(20 + i); in_value = 64'(200 + i);
      tick();
    end
    in_valid = 0;
    reset = 1;
    tick();
    reset = 0;
    check("t6_idle", idle, 1'b1);
    check("t6_we", write_enable, 1'b0);
    check("t6_cnt", writes_done_cnt, 64'd0);
    check("t6_ready", in_ready, 1'b1);
    check("t6_err", timeout_err, 1'b0);

    // randomized traffic with varying register-file responsiveness
    auto_done = 1;
    for (int seg = 0; seg < 8; seg++) begin
      done_pct = (seg == 2 || seg == 5) ? 0 : $urandom_range(10, 100);
      for (int c = 0; c < 250; c++) begin
        reset      = ($urandom_range(0, 299) == 0);
        in_valid   = $urandom_range(0, 1);
        in_rd      = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
        in_value   = {$urandom, $urandom};
        query_reg1 = 5'($urandom_range(0, 7));
        query_reg2 = 5'($urandom_range(0, 7));
        tick();
      end
    end
    reset = 0; in_valid = 0; done_pct = 100;
    repeat (30) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
